// File: rtl/mem_pkg.sv
// Shared types for the data-side memory path: access widths, region map,
// controller states and the lane/byte-enable helpers.
package mem;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        WORD  = 2'd1,
        DWORD = 2'd2
    } width_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RAM_WR  = 3'd1,
        S_RAM_RD  = 3'd2,
        S_IO_WAIT = 3'd3,
        S_DONE    = 3'd4
    } ctrl_state_t;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] IO_TIMEOUT_DATA = 32'hDEAD_BEEF;

    // Any encoding other than BYTE/WORD is handled as a full DWORD.
    function automatic logic [3:0] lane_be(input width_t w, input logic [1:0] lane);
        case (w)
            BYTE:    return 4'b0001 << lane;
            WORD:    return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input width_t w, input logic [1:0] lane);
        case (w)
            BYTE:    return 1'b0;
            WORD:    return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/memory_bus.sv
// CPU MEM/WB stage to data memory controller handshake.
interface memory_bus;
    import mem::*;

    logic [31:0] addr;
    width_t      mem_width;
    logic [31:0] write_data;
    logic        dispatch_read;
    logic        dispatch_write;
    logic [31:0] read_data;
    logic        busy;

    modport master (
        output addr, mem_width, write_data, dispatch_read, dispatch_write,
        input  read_data, busy
    );

    modport slave (
        input  addr, mem_width, write_data, dispatch_read, dispatch_write,
        output read_data, busy
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering: replicate write data across lanes with byte enables,
// and pull the addressed lanes of a read word down to bit 0, zero-filled.
module mem_lane_align
    import mem::*;
(
    input  width_t      i_width,
    input  logic [1:0]  i_lane,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_rdata
);
    logic [31:0] w_shr;

    // Replication lands the datum in every lane it may target; be picks one.
    always_comb begin
        case (i_width)
            BYTE:    o_wdata = {4{i_wdata[7:0]}};
            WORD:    o_wdata = {2{i_wdata[15:0]}};
            default: o_wdata = i_wdata;
        endcase
    end

    assign o_be  = lane_be(i_width, i_lane);
    assign w_shr = i_rword >> {i_lane, 3'b000};

    always_comb begin
        case (i_width)
            BYTE:    o_rdata = {24'h0, w_shr[7:0]};
            WORD:    o_rdata = {16'h0, w_shr[15:0]};
            default: o_rdata = w_shr;
        endcase
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: decodes CPU dispatch pulses into byte-enabled BRAM
// accesses or MMIO req/ack transactions, with sticky error reporting.
module data_mem_ctrl
    import mem::*;
#(
    parameter int          RAM_ADDR_W   = 14,
    parameter int          BRAM_LATENCY = 2,
    parameter logic [31:0] IO_BASE      = IO_BASE_DEFAULT,
    parameter int          IO_TIMEOUT   = 64
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    memory_bus.slave              mem_bus,
    output logic [RAM_ADDR_W-1:0] bram_addr,
    output logic [3:0]            bram_we,
    output logic [31:0]           bram_din,
    input  logic [31:0]           bram_dout,
    output logic                  io_req,
    output logic                  io_we,
    output logic [31:0]           io_addr,
    output logic [31:0]           io_wdata,
    output logic [3:0]            io_be,
    input  logic [31:0]           io_rdata,
    input  logic                  io_ack,
    output logic                  err
);
    localparam int CNT_MAX = (IO_TIMEOUT > BRAM_LATENCY) ? IO_TIMEOUT : BRAM_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    ctrl_state_t      r_state;
    width_t           r_width;
    logic [1:0]       r_lane;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_read_data;

    logic        w_open;
    logic        w_dispatch;
    width_t      w_width;
    logic [1:0]  w_lane;
    logic [31:0] w_rword;
    logic [31:0] w_wdata_sh;
    logic [3:0]  w_be;
    logic [31:0] w_rdata;

    // DONE is the completion cycle: result is visible and busy is already low,
    // so it accepts a new dispatch exactly like IDLE.
    assign w_open     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_dispatch = mem_bus.dispatch_read | mem_bus.dispatch_write;
    assign w_width    = w_open ? mem_bus.mem_width : r_width;
    assign w_lane     = w_open ? mem_bus.addr[1:0] : r_lane;
    assign w_rword    = (r_state == S_IO_WAIT) ? io_rdata : bram_dout;

    assign mem_bus.busy = (r_state == S_RAM_WR) || (r_state == S_RAM_RD) ||
                          (r_state == S_IO_WAIT) || w_dispatch;
    assign mem_bus.read_data = r_read_data;

    mem_lane_align u_align (
        .i_width (w_width),
        .i_lane  (w_lane),
        .i_wdata (mem_bus.write_data),
        .i_rword (w_rword),
        .o_wdata (w_wdata_sh),
        .o_be    (w_be),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_width     <= BYTE;
            r_lane      <= 2'b00;
            r_cnt       <= '0;
            r_read_data <= '0;
            bram_addr   <= '0;
            bram_we     <= '0;
            bram_din    <= '0;
            io_req      <= 1'b0;
            io_we       <= 1'b0;
            io_addr     <= '0;
            io_wdata    <= '0;
            io_be       <= '0;
            err         <= 1'b0;
        end else begin
            bram_we <= '0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= S_IDLE;
                    if (w_dispatch) begin
                        r_width <= mem_bus.mem_width;
                        r_lane  <= mem_bus.addr[1:0];
                        r_cnt   <= CNT_W'(1);
                        if (is_misaligned(mem_bus.mem_width, mem_bus.addr[1:0])) begin
                            err         <= 1'b1;
                            r_read_data <= '0;
                            r_state     <= S_DONE;
                        end else if (mem_bus.addr >= IO_BASE) begin
                            io_req   <= 1'b1;
                            io_we    <= mem_bus.dispatch_write;
                            io_addr  <= mem_bus.addr;
                            io_wdata <= w_wdata_sh;
                            io_be    <= w_be;
                            r_state  <= S_IO_WAIT;
                        end else begin
                            bram_addr <= mem_bus.addr[RAM_ADDR_W+1:2];
                            bram_din  <= w_wdata_sh;
                            if (mem_bus.dispatch_write) begin
                                bram_we <= w_be;
                                r_state <= S_RAM_WR;
                            end else begin
                                r_state <= S_RAM_RD;
                            end
                        end
                    end
                end
                S_RAM_WR: r_state <= S_DONE;
                S_RAM_RD: begin
                    if (r_cnt == CNT_W'(BRAM_LATENCY)) begin
                        r_read_data <= w_rdata;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_IO_WAIT: begin
                    if (io_ack) begin
                        io_req  <= 1'b0;
                        r_state <= S_DONE;
                        if (!io_we) r_read_data <= w_rdata;
                    end else if (r_cnt == CNT_W'(IO_TIMEOUT)) begin
                        io_req      <= 1'b0;
                        err         <= 1'b1;
                        r_read_data <= IO_TIMEOUT_DATA;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, MMIO/reset sequences and
// randomized RAM traffic against a byte-addressed reference memory.
module tb_data_mem_ctrl;
    import mem::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [13:0] bram_addr;
    logic [3:0]  bram_we;
    logic [31:0] bram_din;
    logic [31:0] bram_dout;
    logic        io_req, io_we;
    logic [31:0] io_addr, io_wdata;
    logic [3:0]  io_be;
    logic [31:0] io_rdata = '0;
    logic        io_ack = 1'b0;
    logic        err;

    memory_bus bus ();

    data_mem_ctrl dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .mem_bus   (bus),
        .bram_addr (bram_addr),
        .bram_we   (bram_we),
        .bram_din  (bram_din),
        .bram_dout (bram_dout),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_be     (io_be),
        .io_rdata  (io_rdata),
        .io_ack    (io_ack),
        .err       (err)
    );

    always #5 clk_in = ~clk_in;

    // BRAM: address register lives in the DUT, one more stage here.
    logic [31:0] bmem [0:16383];
    logic [31:0] dout_q;
    always @(posedge clk_in) begin
        for (int b = 0; b < 4; b++)
            if (bram_we[b]) bmem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
        dout_q <= bmem[bram_addr];
    end
    assign bram_dout = dout_q;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: flat byte memory plus last-read and sticky error.
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] m_last;
    logic        m_err;

    function automatic int wsize(input width_t w);
        return (w == BYTE) ? 1 : (w == WORD) ? 2 : 4;
    endfunction

    task automatic model_write(input logic [31:0] a, input width_t w, input logic [31:0] d);
        for (int i = 0; i < wsize(w); i++) ref_mem[a[15:0] + 16'(i)] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input width_t w);
        logic [31:0] v = '0;
        for (int i = 0; i < wsize(w); i++) v[8*i +: 8] = ref_mem[a[15:0] + 16'(i)];
        return v;
    endfunction

    // Snapshot of MMIO request fields taken in the cycle after dispatch.
    logic [31:0] s_io_addr, s_io_wdata;
    logic        s_io_we;
    logic [3:0]  s_io_be;

    // Entered and left at posedge+1; outputs sampled at negedge.
    task automatic run(input bit wr, input bit rd, input width_t w, input logic [31:0] a,
                       input logic [31:0] d, input int ack_at, input logic [31:0] ack_data,
                       output int lat, output int we_cnt, output logic [3:0] we_val,
                       output int req_cnt, output bit busy0);
        lat = -1; we_cnt = 0; we_val = '0; req_cnt = 0; busy0 = 1'b0;
        bus.addr = a; bus.mem_width = w; bus.write_data = d;
        bus.dispatch_write = wr; bus.dispatch_read = rd;
        for (int k = 0; k < 200; k++) begin
            if (k == ack_at) begin io_ack = 1'b1; io_rdata = ack_data; end
            @(negedge clk_in);
            if (bram_we != 4'b0) begin we_cnt++; we_val = bram_we; end
            if (io_req) req_cnt++;
            if (k == 1) begin
                s_io_addr = io_addr; s_io_wdata = io_wdata; s_io_we = io_we; s_io_be = io_be;
            end
            if (k == 0) busy0 = bus.busy;
            else if (!bus.busy) begin lat = k; break; end
            @(posedge clk_in); #1;
            bus.dispatch_write = 1'b0; bus.dispatch_read = 1'b0; io_ack = 1'b0;
        end
        if (lat < 0) $display("FAIL busy_release: got stuck want release within 200 cycles");
        @(posedge clk_in); #1;
        bus.dispatch_write = 1'b0; bus.dispatch_read = 1'b0; io_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        bit          rd;
        width_t      w;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        logic [3:0]  we;
        logic [31:0] rdat;
        bit          er;
    } vec_t;

    vec_t tv [11];

    initial begin
        int lat, we_cnt, req_cnt;
        logic [3:0] we_val;
        bit busy0;

        bus.addr = '0; bus.mem_width = BYTE; bus.write_data = '0;
        bus.dispatch_read = 1'b0; bus.dispatch_write = 1'b0;

        tv[0]  = '{1'b1, 1'b0, DWORD, 32'h10,        32'h1234_5678, 2, 4'hF, 32'h0,         1'b0};
        tv[1]  = '{1'b0, 1'b1, DWORD, 32'h10,        32'h0,         3, 4'h0, 32'h1234_5678, 1'b0};
        tv[2]  = '{1'b1, 1'b0, BYTE,  32'h13,        32'hAB,        2, 4'h8, 32'h1234_5678, 1'b0};
        tv[3]  = '{1'b0, 1'b1, DWORD, 32'h10,        32'h0,         3, 4'h0, 32'hAB34_5678, 1'b0};
        tv[4]  = '{1'b0, 1'b1, BYTE,  32'h13,        32'h0,         3, 4'h0, 32'h0000_00AB, 1'b0};
        tv[5]  = '{1'b1, 1'b0, WORD,  32'h12,        32'hBEEF,      2, 4'hC, 32'h0000_00AB, 1'b0};
        tv[6]  = '{1'b0, 1'b1, WORD,  32'h12,        32'h0,         3, 4'h0, 32'h0000_BEEF, 1'b0};
        tv[7]  = '{1'b0, 1'b1, BYTE,  32'h11,        32'h0,         3, 4'h0, 32'h0000_0056, 1'b0};
        tv[8]  = '{1'b1, 1'b1, DWORD, 32'h14,        32'hA5A5_0F0F, 2, 4'hF, 32'h0000_0056, 1'b0};
        tv[9]  = '{1'b0, 1'b1, DWORD, 32'h0001_0014, 32'h0,         3, 4'h0, 32'hA5A5_0F0F, 1'b0};
        tv[10] = '{1'b0, 1'b1, WORD,  32'h11,        32'h0,         1, 4'h0, 32'h0,         1'b1};

        // Reset values
        do_reset();
        @(negedge clk_in);
        chk("rst bram_we",   32'(bram_we),   32'h0);
        chk("rst bram_addr", 32'(bram_addr), 32'h0);
        chk("rst bram_din",  bram_din,       32'h0);
        chk("rst io_req",    32'(io_req),    32'h0);
        chk("rst io_we",     32'(io_we),     32'h0);
        chk("rst io_addr",   io_addr,        32'h0);
        chk("rst read_data", bus.read_data,  32'h0);
        chk("rst err",       32'(err),       32'h0);
        chk("rst busy",      32'(bus.busy),  32'h0);
        @(posedge clk_in); #1;

        // Stray ack while idle must be ignored
        io_ack = 1'b1;
        @(negedge clk_in);
        chk("stray io_req", 32'(io_req),   32'h0);
        chk("stray busy",   32'(bus.busy), 32'h0);
        @(posedge clk_in); #1 io_ack = 1'b0;
        @(negedge clk_in);
        chk("stray err",    32'(err),      32'h0);
        @(posedge clk_in); #1;

        // MMIO read, ack in cycle 5
        run(1'b0, 1'b1, DWORD, 32'h8000_0004, 32'h0, 5, 32'hCAFE_F00D, lat, we_cnt, we_val, req_cnt, busy0);
        chk("ioread lat",     32'(lat),      32'd6);
        chk("ioread req_cnt", 32'(req_cnt),  32'd5);
        chk("ioread data",    bus.read_data, 32'hCAFE_F00D);
        chk("ioread addr",    s_io_addr,     32'h8000_0004);
        chk("ioread we",      32'(s_io_we),  32'h0);
        chk("ioread bram_we", 32'(we_cnt),   32'h0);
        chk("ioread err",     32'(err),      32'h0);

        // MMIO write, never acked
        run(1'b1, 1'b0, BYTE, 32'h8000_0012, 32'h0000_005A, -1, 32'h0, lat, we_cnt, we_val, req_cnt, busy0);
        chk("iotmo lat",     32'(lat),      32'd65);
        chk("iotmo req_cnt", 32'(req_cnt),  32'd64);
        chk("iotmo io_req",  32'(io_req),   32'h0);
        chk("iotmo err",     32'(err),      32'h1);
        chk("iotmo data",    bus.read_data, 32'hDEAD_BEEF);
        chk("iotmo io_we",   32'(s_io_we),  32'h1);
        chk("iotmo io_be",   32'(s_io_be),  32'h4);
        chk("iotmo wdata",   s_io_wdata,    32'h5A5A_5A5A);

        do_reset();
        @(negedge clk_in);
        chk("rst2 err", 32'(err), 32'h0);
        @(posedge clk_in); #1;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            run(tv[i].wr, tv[i].rd, tv[i].w, tv[i].a, tv[i].d, -1, 32'h0, lat, we_cnt, we_val, req_cnt, busy0);
            if (tv[i].wr && tv[i].lat != 1) model_write(tv[i].a, tv[i].w, tv[i].d);
            chk($sformatf("tv%0d busy0", i),   32'(busy0),   32'h1);
            chk($sformatf("tv%0d lat", i),     32'(lat),     32'(tv[i].lat));
            chk($sformatf("tv%0d we", i),      32'(we_val),  32'(tv[i].we));
            chk($sformatf("tv%0d we_cnt", i),  32'(we_cnt),  (tv[i].we != 4'h0) ? 32'd1 : 32'd0);
            chk($sformatf("tv%0d rdata", i),   bus.read_data, tv[i].rdat);
            chk($sformatf("tv%0d err", i),     32'(err),     32'(tv[i].er));
            chk($sformatf("tv%0d io_req", i),  32'(req_cnt), 32'h0);
        end

        // Reset in the middle of a RAM read
        run(1'b0, 1'b1, DWORD, 32'h14, 32'h0, -1, 32'h0, lat, we_cnt, we_val, req_cnt, busy0);
        chk("pre rdata", bus.read_data, 32'hA5A5_0F0F);
        bus.addr = 32'h10; bus.mem_width = DWORD; bus.dispatch_read = 1'b1;
        @(posedge clk_in); #1 bus.dispatch_read = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        chk("midrst bram_we",   32'(bram_we),   32'h0);
        chk("midrst bram_addr", 32'(bram_addr), 32'h0);
        chk("midrst io_req",    32'(io_req),    32'h0);
        chk("midrst read_data", bus.read_data,  32'h0);
        chk("midrst err",       32'(err),       32'h0);
        chk("midrst busy",      32'(bus.busy),  32'h0);
        @(negedge clk_in) rst_in = 1'b0;
        @(posedge clk_in); #1;
        run(1'b0, 1'b1, DWORD, 32'h10, 32'h0, -1, 32'h0, lat, we_cnt, we_val, req_cnt, busy0);
        chk("postrst lat",   32'(lat),      32'd3);
        chk("postrst rdata", bus.read_data, model_read(32'h10, DWORD));
        m_last = model_read(32'h10, DWORD);
        m_err  = 1'b0;

        // Preload the random window with known words
        for (int i = 0; i < 16; i++) begin
            logic [31:0] d = $urandom;
            run(1'b1, 1'b0, DWORD, 32'(4*i), d, -1, 32'h0, lat, we_cnt, we_val, req_cnt, busy0);
            model_write(32'(4*i), DWORD, d);
            chk($sformatf("pre%0d lat", i), 32'(lat),    32'd2);
            chk($sformatf("pre%0d we", i),  32'(we_val), 32'hF);
        end

        // Randomized RAM traffic
        for (int n = 0; n < 250; n++) begin
            width_t      w  = width_t'($urandom_range(0, 2));
            int          op = $urandom_range(0, 2);
            logic [31:0] a  = (32'($urandom_range(0, 3)) << 16) | 32'($urandom_range(0, 63));
            logic [31:0] d  = $urandom;
            bit          wr = (op != 0);
            int          s  = wsize(w);
            bit          mis;
            int          e_lat;
            logic [3:0]  e_we;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(s - 1);
            mis   = (int'(a[1:0]) % s) != 0;
            e_lat = mis ? 1 : (wr ? 2 : 3);
            e_we  = (mis || !wr) ? 4'h0 : 4'(((1 << s) - 1) << a[1:0]);
            run(wr, (op != 1), w, a, d, -1, 32'h0, lat, we_cnt, we_val, req_cnt, busy0);
            if (mis) begin
                m_err = 1'b1; m_last = '0;
            end else if (wr) begin
                model_write(a, w, d);
            end else begin
                m_last = model_read(a, w);
            end
            chk($sformatf("r%0d lat", n),    32'(lat),      32'(e_lat));
            chk($sformatf("r%0d we", n),     32'(we_val),   32'(e_we));
            chk($sformatf("r%0d rdata", n),  bus.read_data, m_last);
            chk($sformatf("r%0d err", n),    32'(err),      32'(m_err));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before 2ms");
        $fatal(1, "watchdog expired");
    end
endmodule
